// File: rtl/ysyx_23060236_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_rd_arbiter_pkg
// Brief    : Shared state encodings and constants for the IFU/LSU read arbiter
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060236_rd_arbiter_pkg;

  // Arbiter states, 3-bit encoded
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_IFU_AR = 3'd1,
    ARB_IFU_R  = 3'd2,
    ARB_LSU_AR = 3'd3,
    ARB_LSU_R  = 3'd4
  } arb_state_t;

  // Instruction fetches are always full 32-bit words
  localparam logic [2:0] c_IFU_ARSIZE = 3'b010;

  // True while the IFU owns the shared read port
  function automatic logic arb_is_ifu(input arb_state_t s);
    return (s == ARB_IFU_AR) || (s == ARB_IFU_R);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_arb_pick
// Brief    : Combinational winner select between IFU and LSU read requests.
//            ARB_RR_EN defined  -> round-robin on ties using last-served flag
//            ARB_RR_EN undefined -> fixed priority, LSU wins ties
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_arb_pick (
  input  logic i_ifu_req,
  input  logic i_lsu_req,
`ifdef ARB_RR_EN
  input  logic i_last_ifu,
`endif
  output logic o_grant_ifu,
  output logic o_grant_lsu
);

  // One-hot (or empty) grant; a tie is the only case needing a policy
  always_comb begin
    o_grant_ifu = 1'b0;
    o_grant_lsu = 1'b0;
    if (i_ifu_req && i_lsu_req) begin
`ifdef ARB_RR_EN
      o_grant_ifu = ~i_last_ifu;
      o_grant_lsu = i_last_ifu;
`else
      o_grant_lsu = 1'b1;
`endif
    end else begin
      o_grant_ifu = i_ifu_req;
      o_grant_lsu = i_lsu_req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_rd_arbiter
// Brief    : Two-master AXI-lite read arbiter (IFU fetch / LSU load) sharing
//            one read port. One outstanding transaction; the grant is held
//            from AR acceptance through the R handshake.
//            Optional macro ARB_RR_EN selects round-robin tie breaking,
//            otherwise LSU has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_rd_arbiter
  import ysyx_23060236_rd_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // IFU read master
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  // LSU read master
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  // Shared memory-side read port
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  output logic [2:0]        mem_arsize,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready
);

  arb_state_t r_state;
  logic       w_grant_ifu;
  logic       w_grant_lsu;
  logic       w_ar_hs;
  logic       w_r_hs;

  assign w_ar_hs = mem_arvalid & mem_arready;
  assign w_r_hs  = mem_rvalid & mem_rready;

`ifdef ARB_RR_EN
  logic r_last_ifu;

  // Track who was served last; reset value makes IFU win the first tie
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_ifu <= 1'b0;
    end else if (w_r_hs) begin
      r_last_ifu <= arb_is_ifu(r_state);
    end
  end
`endif

  ysyx_23060236_arb_pick u_pick (
    .i_ifu_req   (ifu_arvalid),
    .i_lsu_req   (lsu_arvalid),
`ifdef ARB_RR_EN
    .i_last_ifu  (r_last_ifu),
`endif
    .o_grant_ifu (w_grant_ifu),
    .o_grant_lsu (w_grant_lsu)
  );

  // Grant FSM: pick in IDLE, hold the owner through AR and R handshakes
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_lsu) begin
            r_state <= ARB_LSU_AR;
          end else if (w_grant_ifu) begin
            r_state <= ARB_IFU_AR;
          end
        end
        ARB_IFU_AR: if (w_ar_hs) r_state <= ARB_IFU_R;
        ARB_IFU_R:  if (w_r_hs)  r_state <= ARB_IDLE;
        ARB_LSU_AR: if (w_ar_hs) r_state <= ARB_LSU_R;
        ARB_LSU_R:  if (w_r_hs)  r_state <= ARB_IDLE;
        default:    r_state <= ARB_IDLE;
      endcase
    end
  end

  // Channel steering decoded from the registered state only
  always_comb begin
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_arsize  = 3'b000;
    mem_rready  = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    case (r_state)
      ARB_IFU_AR: begin
        mem_araddr  = ifu_araddr;
        mem_arvalid = ifu_arvalid;
        mem_arsize  = c_IFU_ARSIZE;
        ifu_arready = mem_arready;
      end
      ARB_IFU_R: begin
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
        ifu_rvalid = mem_rvalid;
        mem_rready = ifu_rready;
      end
      ARB_LSU_AR: begin
        mem_araddr  = lsu_araddr;
        mem_arvalid = lsu_arvalid;
        mem_arsize  = lsu_arsize;
        lsu_arready = mem_arready;
      end
      ARB_LSU_R: begin
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
        lsu_rvalid = mem_rvalid;
        mem_rready = lsu_rready;
      end
      default: begin
      end
    endcase
  end

`ifndef SYNTHESIS
  // Flag masters that withdraw a request before it is accepted; grant is kept
  always_ff @(posedge clock) begin
    if (reset) begin
      if (r_state == ARB_IFU_AR) begin
        assert (ifu_arvalid) else $error("rd_arbiter: ifu_arvalid dropped before arready");
      end
      if (r_state == ARB_LSU_AR) begin
        assert (lsu_arvalid) else $error("rd_arbiter: lsu_arvalid dropped before arready");
      end
    end
  end
`endif

endmodule
`default_nettype wire
